// File: rtl/j_field_accum_if.sv
// Bus bundle for j_field_accum: sweep control, BRAM read port and field output stream.
// master is the accumulator side; slave is the surrounding environment.
interface j_field_accum_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned ACC_W  = 10
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic                     start;
  logic [N-1:0]             spins;
  logic                     en_read;
  logic [ADDR_W-1:0]        count_addr;
  logic signed [WIDTH-1:0]  J;
  logic                     field_valid;
  logic [IdxW-1:0]          field_idx;
  logic signed [ACC_W-1:0]  field;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, spins, J,
    output en_read, count_addr, field_valid, field_idx, field, busy, done
  );

  modport slave (
    output start, spins, J,
    input  en_read, count_addr, field_valid, field_idx, field, busy, done
  );
endinterface

// File: rtl/j_field_accum.sv
// Sweeps the N x N coupling matrix out of BRAM and emits the local field
// h_i = sum_{j!=i} J[i][j]*s_j for every row, one address per cycle.
module j_field_accum #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ACC_W  = 10
) (
  input  logic            clk,
  input  logic            rst,
  j_field_accum_if.master bus
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NSq  = N * N;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       spins_q;
  logic               en_q, en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IdxW-1:0]    row_q, row_d, col_q, col_d;
  logic               latch;

  logic [RD_LAT-1:0]  vld_q;
  logic [IdxW-1:0]    ti_q [RD_LAT];
  logic [IdxW-1:0]    tj_q [RD_LAT];

  logic signed [ACC_W-1:0] acc_q, field_q, j_ext, term, sum;
  logic                    fv_q, done_q;
  logic [IdxW-1:0]         fidx_q;
  logic                    tv;
  logic [IdxW-1:0]         ti, tj;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    row_d   = row_q;
    col_d   = col_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StIssue;
          en_d    = 1'b1;
          addr_d  = '0;
          row_d   = '0;
          col_d   = '0;
          latch   = 1'b1;
        end
      end
      StIssue: begin
        if (addr_q == ADDR_W'(NSq - 1)) begin
          state_d = StDrain;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == IdxW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + IdxW'(1);
          end else begin
            col_d = col_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        if (done_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      spins_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (latch) spins_q <= bus.spins;
    end
  end

  // Tags travel alongside the read so data is matched to (i,j) without stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        ti_q[s] <= '0;
        tj_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= en_q;
      ti_q[0]  <= row_q;
      tj_q[0]  <= col_q;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        ti_q[s]  <= ti_q[s-1];
        tj_q[s]  <= tj_q[s-1];
      end
    end
  end

  assign tv    = vld_q[RD_LAT-1];
  assign ti    = ti_q[RD_LAT-1];
  assign tj    = tj_q[RD_LAT-1];
  assign j_ext = {{(ACC_W - WIDTH){bus.J[WIDTH-1]}}, bus.J};

  always_comb begin
    term = '0;
    if (ti != tj) term = spins_q[tj] ? j_ext : -j_ext;
    sum = (tj == '0) ? term : acc_q + term;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      field_q <= '0;
      fidx_q  <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fv_q   <= 1'b0;
      done_q <= 1'b0;
      if (tv) begin
        acc_q <= sum;
        if (tj == IdxW'(N - 1)) begin
          fv_q    <= 1'b1;
          field_q <= sum;
          fidx_q  <= ti;
          done_q  <= (ti == IdxW'(N - 1));
        end
      end
    end
  end

  assign bus.en_read     = en_q;
  assign bus.count_addr  = addr_q;
  assign bus.field_valid = fv_q;
  assign bus.field_idx   = fidx_q;
  assign bus.field       = field_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_j_field_accum.sv
// Bench for j_field_accum: three instances (N=4/RD_LAT=1, N=4/RD_LAT=2, N=16/RD_LAT=1)
// checked every cycle against a timing/arithmetic model, plus hand-computed literals.
module tb_j_field_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  j_field_accum_if #(.WIDTH(4), .N(4),  .ADDR_W(20), .ACC_W(10)) ia ();
  j_field_accum_if #(.WIDTH(4), .N(4),  .ADDR_W(20), .ACC_W(10)) ib ();
  j_field_accum_if #(.WIDTH(4), .N(16), .ADDR_W(20), .ACC_W(10)) ic ();

  j_field_accum #(.WIDTH(4), .N(4), .ADDR_W(20), .RD_LAT(1), .ACC_W(10)) u_a (
    .clk(clk), .rst(rst), .bus(ia));
  j_field_accum #(.WIDTH(4), .N(4), .ADDR_W(20), .RD_LAT(2), .ACC_W(10)) u_b (
    .clk(clk), .rst(rst), .bus(ib));
  j_field_accum #(.WIDTH(4), .N(16), .ADDR_W(20), .RD_LAT(1), .ACC_W(10)) u_c (
    .clk(clk), .rst(rst), .bus(ic));

  int total = 0;
  int bad   = 0;
  int pat   = 0;

  int          nn [3] = '{4, 4, 16};
  int          ll [3] = '{1, 2, 1};
  string       nm [3] = '{"a", "b", "c"};
  bit          act [3];
  int          t [3];
  int          hf [3];
  int          hi [3];
  int          ha [3];
  logic [15:0] lsp [3];
  int          lpat [3];
  int          obs_f [3][16];
  int          obs_done [3];
  int          done_cnt [3];
  int          fv_cnt [3];

  function automatic int jval(input int p, input int n, input int a);
    int i = a / n;
    int j = a % n;
    case (p)
      0:       return 1;
      1:       return -8;
      2:       return 7;
      3:       return i + j;
      default: return ((a * 5 + 3) % 16) - 8;
    endcase
  endfunction

  function automatic int mfield(input int k, input int i);
    int s = 0;
    for (int j = 0; j < nn[k]; j++) begin
      if (j != i) begin
        int v = jval(lpat[k], nn[k], i * nn[k] + j);
        s += lsp[k][j] ? v : -v;
      end
    end
    return s;
  endfunction

  // BRAM models; data off the enabled cycles is junk that must be ignored.
  logic signed [3:0] jb1;
  always @(posedge clk) ia.J <= ia.en_read ? 4'(jval(pat, 4, int'(ia.count_addr))) : 4'sb1001;
  always @(posedge clk) begin
    jb1  <= ib.en_read ? 4'(jval(pat, 4, int'(ib.count_addr))) : 4'sb1001;
    ib.J <= jb1;
  end
  always @(posedge clk) ic.J <= ic.en_read ? 4'(jval(pat, 16, int'(ic.count_addr))) : 4'sb0110;

  task automatic ck(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic st, input logic [15:0] sp, input logic en,
                     input int addr, input logic fv, input int idx, input int fld,
                     input logic bsy, input logic dn);
    int n, l, tt, e_en, e_fv, e_dn, e_bsy;
    n = nn[k]; l = ll[k]; tt = n * n + 1 + l;
    e_en = 0; e_fv = 0; e_dn = 0; e_bsy = 0;
    if (act[k]) begin
      e_bsy = 1;
      if (t[k] <= n * n) begin
        e_en  = 1;
        ha[k] = t[k] - 1;
      end
      if (t[k] >= n + 1 + l && (t[k] - 1 - l) % n == 0) begin
        e_fv  = 1;
        hi[k] = (t[k] - 1 - l) / n - 1;
        hf[k] = mfield(k, hi[k]);
      end
      e_dn = (t[k] == tt) ? 1 : 0;
    end
    ck({nm[k], "_busy"}, int'(bsy), e_bsy);
    ck({nm[k], "_en_read"}, int'(en), e_en);
    ck({nm[k], "_count_addr"}, addr, ha[k]);
    ck({nm[k], "_field_valid"}, int'(fv), e_fv);
    ck({nm[k], "_done"}, int'(dn), e_dn);
    ck({nm[k], "_field_idx"}, idx, hi[k]);
    ck({nm[k], "_field"}, fld, hf[k]);
    if (fv) begin
      obs_f[k][idx] = fld;
      fv_cnt[k]++;
    end
    if (dn) begin
      obs_done[k] = t[k];
      done_cnt[k]++;
    end
    if (rst) begin
      act[k] = 1'b0; t[k] = 0; hf[k] = 0; hi[k] = 0; ha[k] = 0;
    end else if (act[k]) begin
      t[k]++;
      if (t[k] > tt) act[k] = 1'b0;
    end else if (st) begin
      act[k] = 1'b1; t[k] = 1; lsp[k] = sp; lpat[k] = pat;
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp(0, ia.start, 16'(ia.spins), ia.en_read, int'(ia.count_addr), ia.field_valid,
          int'(ia.field_idx), int'(ia.field), ia.busy, ia.done);
      cmp(1, ib.start, 16'(ib.spins), ib.en_read, int'(ib.count_addr), ib.field_valid,
          int'(ib.field_idx), int'(ib.field), ib.busy, ib.done);
      cmp(2, ic.start, ic.spins, ic.en_read, int'(ic.count_addr), ic.field_valid,
          int'(ic.field_idx), int'(ic.field), ic.busy, ic.done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input logic s, input logic [15:0] sp);
    case (k)
      0:       begin ia.start = s; ia.spins = sp[3:0]; end
      1:       begin ib.start = s; ib.spins = sp[3:0]; end
      default: begin ic.start = s; ic.spins = sp; end
    endcase
  endtask

  int snap;

  initial begin
    set_in(0, 1'b0, 16'h0);
    set_in(1, 1'b0, 16'h0);
    set_in(2, 1'b0, 16'h0);
    repeat (3) step();
    rst = 1'b0;
    step();

    // all J=+1, all spins +1; spins wiggle mid-sweep without effect
    pat = 0;
    set_in(0, 1'b1, 16'hF); step();
    set_in(0, 1'b0, 16'hA);
    repeat (25) step();
    ck("lit_a_done_cycle", obs_done[0], 18);
    for (int i = 0; i < 4; i++) ck("lit_a_ones_field", obs_f[0][i], 3);

    // all J=-8, spins 0101; diagonal excluded
    pat = 1;
    set_in(0, 1'b1, 16'h5); step();
    set_in(0, 1'b0, 16'h5);
    repeat (25) step();
    ck("lit_a_neg8_row0", obs_f[0][0], 8);
    ck("lit_a_neg8_row1", obs_f[0][1], -8);
    ck("lit_a_neg8_row3", obs_f[0][3], -8);

    // RD_LAT=2, J[i][j]=i+j
    pat = 3;
    set_in(1, 1'b1, 16'hF); step();
    set_in(1, 1'b0, 16'hF);
    repeat (25) step();
    ck("lit_b_done_cycle", obs_done[1], 19);
    ck("lit_b_row0", obs_f[1][0], 6);
    ck("lit_b_row3", obs_f[1][3], 12);

    // N=16 extremes
    pat = 2;
    set_in(2, 1'b1, 16'hFFFF); step();
    set_in(2, 1'b0, 16'hFFFF);
    repeat (270) step();
    ck("lit_c_pos7_row0", obs_f[2][0], 105);
    ck("lit_c_pos7_row15", obs_f[2][15], 105);
    pat = 1;
    set_in(2, 1'b1, 16'hFFFF); step();
    set_in(2, 1'b0, 16'hFFFF);
    repeat (270) step();
    ck("lit_c_neg8_row7", obs_f[2][7], -120);

    // start held 30 cycles: one sweep, then re-accepted right after busy falls
    pat = 4;
    snap = done_cnt[0];
    set_in(0, 1'b1, 16'h6);
    repeat (30) step();
    set_in(0, 1'b0, 16'h6);
    repeat (30) step();
    ck("lit_a_held_start_sweeps", done_cnt[0] - snap, 2);
    ck("lit_a_mixed_row0", obs_f[0][0], 11);

    // reset in cycle 9 of a sweep
    pat = 0;
    set_in(0, 1'b1, 16'hF); step();
    set_in(0, 1'b0, 16'hF);
    repeat (8) step();
    rst = 1'b1; step();
    rst = 1'b0;
    snap = fv_cnt[0] + done_cnt[0];
    repeat (20) step();
    ck("lit_a_quiet_after_rst", fv_cnt[0] + done_cnt[0], snap);
    pat = 3;
    set_in(0, 1'b1, 16'hB); step();
    set_in(0, 1'b0, 16'hB);
    repeat (25) step();
    ck("lit_a_after_rst_row0", obs_f[0][0], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/j_field_accum.md
Name: j_field_accum

Overview:
- Downstream consumer of the coupling-coefficient BRAM.
- On `start`, sweeps the BRAM read port over the full N×N J matrix in row-major order and forms the local field h_i = sum over j≠i of J[i][j]·s_j, with s_j = ±1 taken from the spin vector.
- Emits one field value per row to the annealing spin-update stage.
- Absorbs the BRAM read latency with a tagged valid pipeline, so one address is issued per cycle with no bubbles.

Parameters:
- WIDTH, 4, signed J coefficient width; matches the BRAM data width.
- N, 16, number of spins; J matrix is N×N at address i·N+j.
- ADDR_W, 20, BRAM read address width.
- RD_LAT, 1, BRAM read latency in cycles after the enable/address cycle; legal values 1 or 2.
- ACC_W, 10, signed field width; must be ≥ WIDTH+clog2(N)+1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- spins  in  N  spin vector; bit j=1 means s_j=+1, bit j=0 means s_j=−1; latched on accepted start.
- en_read  out  1  BRAM read-port enable.
- count_addr  out  ADDR_W  BRAM read address.
- J  in  WIDTH  signed BRAM read data; valid RD_LAT cycles after the matching en_read cycle.
- field_valid  out  1  one-cycle pulse; field/field_idx valid.
- field_idx  out  clog2(N)  row index i of the emitted field.
- field  out  ACC_W  signed h_i.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse, coincident with the last row's field_valid.

Behaviour:
- Reset values: en_read=0, count_addr=0, field_valid=0, field_idx=0, field=0, busy=0, done=0. The accumulator, latched spins and valid/tag pipeline are all cleared; FSM goes to IDLE.
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE→ISSUE: start=1 in cycle 0. Spins are latched and busy=1 from cycle 1.
- ISSUE: in cycles 1..N², en_read=1 and count_addr=k−1 in cycle k. After address N²−1 is issued, go to DRAIN; en_read=0 and count_addr holds.
- DRAIN→IDLE: in the cycle done pulses. busy falls in the following cycle.
- Read pipeline:
  - Each issued address carries a valid bit plus (i,j) tags through RD_LAT register stages.
  - J for address a is consumed combinationally in cycle a+1+RD_LAT.
- Term computation:
  - J is sign-extended to ACC_W.
  - term = +J if s_j=1, −J if s_j=0.
  - term = 0 when j==i; the diagonal is excluded regardless of memory contents.
- Accumulation:
  - On j==0 the accumulator loads term; otherwise it adds term.
  - Arithmetic is two's complement with no saturation; the ACC_W rule guarantees no overflow.
- Field output:
  - When the tagged term with j==N−1 is accumulated, the next cycle has field_valid=1, field_idx=i and field = final sum.
  - Row i therefore emits in cycle i·N+N+1+RD_LAT.
- Field hold: field and field_idx hold their last value between pulses.
- Sweep timing: the last row emits in cycle N²+1+RD_LAT; done=1 in that same cycle. Total latency from start to done is N²+1+RD_LAT cycles.
- start while busy=1, including the done cycle, is ignored. A new start is accepted the cycle after busy falls.
- spins changing mid-sweep has no effect.
- rst mid-sweep: next cycle all outputs are at reset values. Returning BRAM data is dropped; no field_valid or done follows until a new start.
- The J port is ignored whenever no valid tag is present at the pipeline output.

Test Plan:
- N=4, RD_LAT=1, all J=+1, spins=4'b1111 → field_valid at cycles 6,10,14,18 with field=3 each; field_idx=0..3; done at cycle 18; count_addr 0..15 in cycles 1..16.
- N=4, all J=−8, spins=4'b0101 → rows 0 and 2 give h=+8, rows 1 and 3 give h=−8. Diagonal J=−8 is ignored.
- N=16, WIDTH=4, all J=+7, spins all 1 → each field=105 (no overflow in 10 bits). A second run with all J=−8 and spins all 1 gives −120.
- RD_LAT=2, N=4, J[i][j]=i+j → field values match the golden model; each field_valid lands one cycle later than with RD_LAT=1; done at cycle 19.
- start held high for 30 cycles at N=4 → exactly one sweep, since start is not accepted while busy. Re-accepted the cycle after busy falls; second sweep gives identical results.
- rst asserted at cycle 9 of an N=4 sweep → cycle 10 shows all outputs 0. No field_valid or done for 20 cycles. A fresh start produces correct fields.
